cyclic74_serial_decoder: RTL
============================

// Module: cyclic74_serial_decoder
// PURPOSE
//  Serial (7,4) cyclic-code decoder, g(x)=x^3+x+1. Sits directly downstream of the
//  serial (7,4) encoder and consumes its one-bit-per-clock stream.
//  Computes the syndrome per 7-bit frame, corrects any single-bit error, and emits
//  the 4 corrected data bits serially with a valid strobe and error status.
// PARAMETERS
//  PHASE_INIT  3'd0  phase-counter reset value; top level sets it so phase 0 = first bit of each codeword
//  CNT_W       8     width of saturating corrected-error counter
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  data_in    in   1      serial codeword bit, sampled every clk edge
//  data_out   out  1      corrected data bit, registered
//  out_valid  out  1      high while data_out carries a data bit
//  err_flag   out  1      previous frame had nonzero syndrome; held for one frame
//  syndrome   out  3      syndrome {s2,s1,s0} of previous frame; held for one frame
//  err_cnt    out  CNT_W  count of frames with nonzero syndrome, saturating
// BEHAVIOUR
//  Reset: all outputs 0, phase<=PHASE_INIT, shift/syndrome/buffer regs 0. Partial frame discarded.
//  Frame: phase counts 0..6 and wraps to 0, free-running. Bit at phase p is c(6-p).
//   c6..c3 = d3..d0 (d3 first); c2..c0 = parity = d(x)*x^3 mod g(x).
//  Syndrome LFSR, per edge, with r = data_in: s0'=r^s2, s1'=s0^s2, s2'=s1.
//   At phase 0, the LFSR state s is treated as 000, so each frame starts clean.
//  Rx shift reg (7b) collects bits. At the phase-6 edge, final syndrome S and word are
//   computed combinationally, including the phase-6 bit.
//  Correction map, S -> flipped position: 001->c0, 010->c1, 100->c2, 011->c3,
//   110->c4, 111->c5, 101->c6, 000->none.
//   Flip the indicated bit; only c6..c3 affect the output.
//  Output sequence, all registered:
//   phase-6 edge: load corrected {d2,d1,d0} into out buffer; data_out<=d3; out_valid<=1;
//     err_flag<=(S!=0); syndrome<=S; err_cnt+=1 if S!=0 and not at all-ones.
//   phase-0,1,2 edges: data_out<=d2,d1,d0 in turn; out_valid stays 1.
//   phase-3 edge: data_out<=0; out_valid<=0. Stays 0 through the phase-5 edge.
//   err_flag/syndrome hold until the next phase-6 edge.
//  Latency: each data bit appears 6 clk edges after it is sampled; constant for all bits.
//  Back-to-back frames: no gaps. The buffer load at phase 6 never collides with shift-out,
//   because shift-out ends at phase 2.
//  err_cnt saturates at 2^CNT_W-1 and holds there; cleared only by reset.
//  Double-bit errors are miscorrected; this is not detected (code property).
//  Reset mid-frame: immediate clear. The first full frame starting at phase 0 after
//   release decodes normally.
// TESTING
//  1 frames 0000000 x3 -> data_out 0,0,0,0 per frame; out_valid 4 high/3 low;
//    err_flag=0; err_cnt=0.
//  2 d=1000, tx 1000101 -> out 1,0,0,0; syndrome=000; err_flag=0.
//  3 tx 1010101 (c4 flipped) -> syndrome=110; out 1,0,0,0; err_flag=1; err_cnt=1.
//  4 tx 1000100 (c0 flipped) -> syndrome=001; out 1,0,0,0; err_flag=1.
//    Then a clean frame -> err_flag returns to 0.
//  5 CNT_W=2: five consecutive frames with 1 error each -> err_cnt 1,2,3,3,3;
//    every frame corrected.
//  6 rst_n low at phase 3 of a frame, released 2 clks later -> all outputs 0 during reset.
//    Next full frame 1101001 (d=1101) -> out 1,1,0,1; err_flag=0.

Source files
------------

// File: rtl/cyclic74_serial_decoder.sv
// Serial (7,4) cyclic-code decoder for g(x) = x^3 + x + 1.
// Accepts one codeword bit per clock (c6 first) and computes the syndrome on the fly.
// Corrects any single-bit error and replays the 4 data bits serially,
// together with a valid strobe, the frame's syndrome and a saturating error count.
module cyclic74_serial_decoder #(
  parameter logic [2:0]  PHASE_INIT = 3'd0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  output logic             data_out,
  output logic             out_valid,
  output logic             err_flag,
  output logic [2:0]       syndrome,
  output logic [CNT_W-1:0] err_cnt
);

  logic [2:0] phase;
  logic [2:0] lfsr;
  logic [2:0] s_base;
  logic [2:0] s_next;
  // Holds c6..c1 by the phase-6 edge; c0 is data_in at that edge.
  logic [5:0] rx;
  logic [6:0] word;
  logic [3:0] flip_mask;
  logic [3:0] fixed_d;
  logic [2:0] out_buf;

  // Syndrome step, full received word, and data-bit correction.
  always_comb begin
    s_base    = (phase == 3'd0) ? '0 : lfsr;
    s_next    = {s_base[1], s_base[0] ^ s_base[2], data_in ^ s_base[2]};
    word      = {rx, data_in};
    flip_mask = '0;
    // Only c6..c3 reach the output, so syndromes that point at a parity bit
    // (001, 010, 100) need no flip here.
    case (s_next)
      3'b011:  flip_mask = 4'b0001;
      3'b110:  flip_mask = 4'b0010;
      3'b111:  flip_mask = 4'b0100;
      3'b101:  flip_mask = 4'b1000;
      default: flip_mask = '0;
    endcase
    fixed_d = word[6:3] ^ flip_mask;
  end

  // Free-running frame phase, syndrome LFSR and receive shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PHASE_INIT;
      lfsr  <= '0;
      rx    <= '0;
    end else begin
      phase <= (phase == 3'd6) ? 3'd0 : phase + 3'd1;
      lfsr  <= s_next;
      rx    <= {rx[4:0], data_in};
    end
  end

  // Output sequencing: load at phase 6, shift out at phases 0..2, idle from phase 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_buf   <= '0;
      data_out  <= 1'b0;
      out_valid <= 1'b0;
      err_flag  <= 1'b0;
      syndrome  <= '0;
      err_cnt   <= '0;
    end else if (phase == 3'd6) begin
      out_buf   <= fixed_d[2:0];
      data_out  <= fixed_d[3];
      out_valid <= 1'b1;
      err_flag  <= |s_next;
      syndrome  <= s_next;
      if ((|s_next) && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_W'(1);
    end else if (phase <= 3'd2) begin
      data_out <= out_buf[2];
      out_buf  <= {out_buf[1:0], 1'b0};
    end else if (phase == 3'd3) begin
      data_out  <= 1'b0;
      out_valid <= 1'b0;
    end
  end

endmodule
